// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard scoreboard.
//   REG_AW_DEF     : default register address width (32 architectural regs).
//   X0             : hard-wired zero register index; never pending, never a hazard.
//   stall_reason_e : why ID is being held, in priority order, for debug/assertions.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [REG_AW_DEF-1:0] X0 = '0;

  typedef enum logic [2:0] {
    SR_NONE      = 3'd0,
    SR_LOAD_USE  = 3'd1,
    SR_RAW_PEND  = 3'd2,
    SR_WAW_PEND  = 3'd3,
    SR_CAP_FULL  = 3'd4
  } stall_reason_e;

endpackage

// File: rtl/hazard_sb_regfile.sv
// hazard_sb_regfile: per-register pending bit-vector for long-latency producers.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears all bits).
//   set_en_i/idx_i : mark a register pending at the next edge.
//   clr_en_i/idx_i : mark a register complete at the next edge.
//   pending_o      : current pending vector; bit 0 (x0) is always 0.
// When set and clear target the same register in one cycle, the set wins.
module hazard_sb_regfile
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en_i,
  input  logic [REG_AW-1:0]   set_idx_i,
  input  logic                clr_en_i,
  input  logic [REG_AW-1:0]   clr_idx_i,
  output logic [NUM_REGS-1:0] pending_o
);

  localparam logic [REG_AW-1:0] RX0 = REG_AW'(X0);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    // Clear first so that a same-cycle set of the same register overrides it.
    if (clr_en_i && (clr_idx_i != RX0)) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i && (set_idx_i != RX0)) pend_d[set_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID/EX hazard unit with a pending-register scoreboard for
// variable-latency producers, an outstanding-op limit, WAW detection, the
// classic load-use check and branch-flush arbitration.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset.
//   id_*                    : instruction currently in ID (sources, dest, kind).
//   ex_mem_read, ex_rd      : load in EX (single-cycle load-use case).
//   wb_done, wb_rd          : a long-latency op completes this cycle.
//   branch_flush            : taken branch/jump resolved in EX.
//   pc_write_en, if_id_write_en : front-end hold (low while stalled).
//   if_id_flush, id_ex_flush     : squash IF/ID, bubble into ID/EX.
//   busy                    : registered, any long-latency op outstanding.
// Optional: define HAZARD_PERF_CNT_EN to add stall_cycles[31:0] and
// flush_count[31:0] free-running (wrapping) event counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int REG_AW          = REG_AW_DEF,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_long_lat,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              wb_done,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              branch_flush,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  if (REG_AW != $clog2(NUM_REGS)) begin : g_bad_aw
    $error("hazard_scoreboard: REG_AW must equal clog2(NUM_REGS)");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max
    $error("hazard_scoreboard: MAX_OUTSTANDING must be at least 1");
  end
  if (CNT_W < $clog2(MAX_OUTSTANDING + 1)) begin : g_bad_cnt
    $error("hazard_scoreboard: CNT_W too narrow for MAX_OUTSTANDING");
  end

  localparam logic [REG_AW-1:0] RX0     = REG_AW'(X0);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pend;
  logic [CNT_W-1:0]    out_q, out_d;
  logic                busy_q, busy_d;

  logic          rs1_live, rs2_live;
  logic          load_use_hit, raw_pend_hit, waw_hit, cap_hit;
  logic          flush_eff;
  logic          stall;
  logic          issue, complete;
  stall_reason_e reason;

  // A source only matters if the instruction reads it and it is not x0.
  assign rs1_live = id_uses_rs1 && (id_rs1 != RX0);
  assign rs2_live = id_uses_rs2 && (id_rs2 != RX0);

  assign load_use_hit = ex_mem_read && (ex_rd != RX0) &&
                        ((rs1_live && (ex_rd == id_rs1)) ||
                         (rs2_live && (ex_rd == id_rs2)));
  // A register completing this cycle still reads as pending: no same-cycle
  // forward from the long-latency writeback path.
  assign raw_pend_hit = (rs1_live && pend[id_rs1]) || (rs2_live && pend[id_rs2]);
  assign waw_hit      = id_rd_we && (id_rd != RX0) && pend[id_rd];
  assign cap_hit      = id_long_lat && (out_q == CNT_MAX);

  // While in reset the front end runs freely and nothing is flushed.
  assign flush_eff = rst_n && branch_flush;

  always_comb begin
    reason = SR_NONE;
    if (rst_n && id_valid && !branch_flush) begin
      if (load_use_hit)      reason = SR_LOAD_USE;
      else if (raw_pend_hit) reason = SR_RAW_PEND;
      else if (waw_hit)      reason = SR_WAW_PEND;
      else if (cap_hit)      reason = SR_CAP_FULL;
    end
  end

  assign stall = (reason != SR_NONE);

  assign pc_write_en    = !stall;
  assign if_id_write_en = !stall;
  assign id_ex_flush    = stall || flush_eff;
  assign if_id_flush    = flush_eff;

  // Long ops writing x0 or nothing are untracked and take no slot.
  assign issue    = id_valid && !stall && !branch_flush && id_long_lat &&
                    id_rd_we && (id_rd != RX0);
  // Completion of a register that is not pending is a protocol error: ignored.
  assign complete = wb_done && (wb_rd != RX0) && pend[wb_rd];

  hazard_sb_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (issue),
    .set_idx_i (id_rd),
    .clr_en_i  (complete),
    .clr_idx_i (wb_rd),
    .pending_o (pend)
  );

  always_comb begin
    out_d = out_q;
    if (issue && !complete) begin
      if (out_q != CNT_MAX) out_d = out_q + CNT_W'(1);
    end else if (complete && !issue) begin
      if (out_q != '0) out_d = out_q - CNT_W'(1);
    end
    busy_d = (out_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall)     stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_eff) flush_count_d  = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, id_rd_we, id_long_lat;
  logic       ex_mem_read, wb_done, branch_flush;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, busy;

  int total = 0;
  int bad   = 0;

  // Observed vector: {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, busy}
  logic [4:0] obs;
  assign obs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, busy};

  localparam logic [4:0] RUN_IDLE   = 5'b11000;
  localparam logic [4:0] RUN_BUSY   = 5'b11001;
  localparam logic [4:0] STALL_IDLE = 5'b00010;
  localparam logic [4:0] STALL_BUSY = 5'b00011;
  localparam logic [4:0] FLUSH_BUSY = 5'b11111;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rd          (id_rd),
    .id_rd_we       (id_rd_we),
    .id_long_lat    (id_long_lat),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .wb_done        (wb_done),
    .wb_rd          (wb_rd),
    .branch_flush   (branch_flush),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_rd_we = 0; id_long_lat = 0;
    ex_mem_read = 0; ex_rd = 0; wb_done = 0; wb_rd = 0; branch_flush = 0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    id_valid = 1; id_long_lat = 1; id_rd_we = 1; id_rd = rd;
  endtask

  task automatic read_reg(input logic [4:0] rs);
    idle();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = rs;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5;
    branch_flush = 1;
    #12;
    total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL reset_outputs: got=%b want=%b", obs, RUN_IDLE);
    end
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    tick(); idle();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5;
    settle(); total++;
    if (obs !== STALL_IDLE) begin
      bad++; $display("FAIL load_use_rs1: got=%b want=%b", obs, STALL_IDLE);
    end
    tick(); ex_rd = 0; id_rs1 = 0;
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL load_use_x0: got=%b want=%b", obs, RUN_IDLE);
    end
    tick(); id_uses_rs1 = 0; id_uses_rs2 = 1; id_rs2 = 9; ex_rd = 9;
    settle(); total++;
    if (obs !== STALL_IDLE) begin
      bad++; $display("FAIL load_use_rs2: got=%b want=%b", obs, STALL_IDLE);
    end
    tick(); id_valid = 0;
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL load_use_invalid: got=%b want=%b", obs, RUN_IDLE);
    end
    tick(); id_valid = 1; id_uses_rs2 = 0;
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL load_use_unused_src: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  task automatic test_long_raw();
    tick(); issue_long(7);
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL raw_issue: got=%b want=%b", obs, RUN_IDLE);
    end
    tick(); read_reg(7);
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL raw_stall1: got=%b want=%b", obs, STALL_BUSY);
    end
    tick();
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL raw_stall2: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); wb_done = 1; wb_rd = 7;
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL raw_no_bypass: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); wb_done = 0; wb_rd = 0;
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL raw_release: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  task automatic test_capacity();
    logic [4:0] want;
    for (int r = 1; r <= 4; r++) begin
      tick(); issue_long(5'(r));
      want = (r > 1) ? RUN_BUSY : RUN_IDLE;
      settle(); total++;
      if (obs !== want) begin
        bad++; $display("FAIL cap_issue_x%0d: got=%b want=%b", r, obs, want);
      end
    end
    tick(); issue_long(9);
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL cap_full: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); wb_done = 1; wb_rd = 1;
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL cap_full_wb_cycle: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); wb_done = 0; wb_rd = 0;
    settle(); total++;
    if (obs !== RUN_BUSY) begin
      bad++; $display("FAIL cap_issue_x9: got=%b want=%b", obs, RUN_BUSY);
    end
    for (int r = 2; r <= 4; r++) begin
      tick(); idle(); wb_done = 1; wb_rd = 5'(r);
      settle(); total++;
      if (obs !== RUN_BUSY) begin
        bad++; $display("FAIL cap_drain_x%0d: got=%b want=%b", r, obs, RUN_BUSY);
      end
    end
    tick(); wb_rd = 9;
    settle(); total++;
    if (obs !== RUN_BUSY) begin
      bad++; $display("FAIL cap_drain_x9: got=%b want=%b", obs, RUN_BUSY);
    end
    tick(); idle();
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL cap_empty: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  task automatic test_waw();
    tick(); issue_long(3);
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL waw_issue: got=%b want=%b", obs, RUN_IDLE);
    end
    tick(); issue_long(3);
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL waw_stall: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); issue_long(0);
    settle(); total++;
    if (obs !== RUN_BUSY) begin
      bad++; $display("FAIL waw_rd0: got=%b want=%b", obs, RUN_BUSY);
    end
    tick(); idle(); wb_done = 1; wb_rd = 3;
    settle(); total++;
    if (obs !== RUN_BUSY) begin
      bad++; $display("FAIL waw_wb: got=%b want=%b", obs, RUN_BUSY);
    end
    tick(); idle();
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL waw_no_slot: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  task automatic test_flush();
    tick(); issue_long(6);
    settle();
    tick(); idle();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 6;
    id_long_lat = 1; id_rd_we = 1; id_rd = 10; branch_flush = 1;
    settle(); total++;
    if (obs !== FLUSH_BUSY) begin
      bad++; $display("FAIL flush_priority: got=%b want=%b", obs, FLUSH_BUSY);
    end
    tick(); read_reg(10);
    settle(); total++;
    if (obs !== RUN_BUSY) begin
      bad++; $display("FAIL flush_no_set: got=%b want=%b", obs, RUN_BUSY);
    end
    tick(); read_reg(6);
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL flush_keeps_sb: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); idle(); wb_done = 1; wb_rd = 6;
    settle();
    tick(); idle();
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL flush_drain: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  task automatic test_protocol();
    tick(); issue_long(5);
    settle();
    tick(); idle(); wb_done = 1; wb_rd = 12;
    settle();
    tick(); wb_rd = 0;
    settle();
    tick(); read_reg(5);
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL proto_bogus_wb: got=%b want=%b", obs, STALL_BUSY);
    end
    tick(); idle(); wb_done = 1; wb_rd = 5;
    settle();
    tick(); idle();
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL proto_drain: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  task automatic test_async_reset();
    tick(); issue_long(4);
    settle();
    tick(); issue_long(8);
    settle();
    tick(); read_reg(4);
    settle(); total++;
    if (obs !== STALL_BUSY) begin
      bad++; $display("FAIL areset_pre: got=%b want=%b", obs, STALL_BUSY);
    end
    #2 rst_n = 0;
    #1; total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL areset_immediate: got=%b want=%b", obs, RUN_IDLE);
    end
    #1 rst_n = 1;
    tick(); read_reg(4);
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL areset_x4_clear: got=%b want=%b", obs, RUN_IDLE);
    end
    tick(); read_reg(8);
    settle(); total++;
    if (obs !== RUN_IDLE) begin
      bad++; $display("FAIL areset_x8_clear: got=%b want=%b", obs, RUN_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_long_raw();
    test_capacity();
    test_waw();
    test_flush();
    test_protocol();
    test_async_reset();
    tick(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
